// File: rtl/hms_clock.sv
// hms_clock: time-of-day counter (HH:MM:SS) with a built-in one-second prescaler,
// run/pause, synchronous time load, 12/24-hour display and an HH:MM alarm.
//
// Parameters
//   TICK_DIV  clock cycles per second (>= 1)
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   en                             run enable; 0 freezes prescaler and time
//   load, load_hh/mm/ss            one-cycle time load request and values
//   alarm_set, alarm_hh/mm         capture alarm time (ignored if out of range)
//   alarm_en, alarm_clr            alarm enable level, latched-alarm clear
//   mode_12h                       display mode (1 = 12-hour)
//   sec, min, hour                 current time, hour always 24-hour
//   disp_hour, pm                  hour in display format, PM flag (12-hour only)
//   tick, day_wrap                 one-cycle pulses: second advance, midnight wrap
//   alarm                          latched alarm flag
//   load_err                       one-cycle pulse on a rejected load
module hms_clock #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] load_hh,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  input  logic       alarm_set,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  input  logic       alarm_en,
  input  logic       alarm_clr,
  input  logic       mode_12h,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [4:0] disp_hour,
  output logic       pm,
  output logic       tick,
  output logic       day_wrap,
  output logic       alarm,
  output logic       load_err
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic [4:0]    alarm_hh_q, alarm_hh_d;
  logic [5:0]    alarm_mm_q, alarm_mm_d;
  logic          tick_q, day_wrap_q, alarm_q, load_err_q;
  logic          tick_d, day_wrap_d, alarm_d, load_err_d;
  logic          advance, load_ok, alarm_ok, fire;

  // Time and prescaler next state; load takes priority over advance.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    advance = 1'b0;
    load_ok = (load_hh <= 5'd23) && (load_mm <= 6'd59) && (load_ss <= 6'd59);
    if (load) begin
      // A rejected load leaves the prescaler frozen too, so no advance is lost or gained.
      if (load_ok) begin
        sec_d   = load_ss;
        min_d   = load_mm;
        hour_d  = load_hh;
        presc_d = '0;
      end
    end else if (en) begin
      if (presc_q == PrescMax) begin
        advance = 1'b1;
        presc_d = '0;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d  = 6'd0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Pulses, alarm registers and alarm latch.
  always_comb begin
    tick_d     = advance;
    day_wrap_d = advance && (hour_d == 5'd0) && (min_d == 6'd0) && (sec_d == 6'd0);
    load_err_d = load && !load_ok;
    // Compare against the resulting time; loads never set advance, so they never fire.
    fire       = advance && alarm_en && (hour_d == alarm_hh_q) && (min_d == alarm_mm_q) &&
                 (sec_d == 6'd0);
    if (fire) begin
      alarm_d = 1'b1;
    end else if (!alarm_en || alarm_clr) begin
      alarm_d = 1'b0;
    end else begin
      alarm_d = alarm_q;
    end
    alarm_ok   = (alarm_hh <= 5'd23) && (alarm_mm <= 6'd59);
    alarm_hh_d = alarm_hh_q;
    alarm_mm_d = alarm_mm_q;
    if (alarm_set && alarm_ok) begin
      alarm_hh_d = alarm_hh;
      alarm_mm_d = alarm_mm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 5'd0;
      alarm_hh_q <= 5'd0;
      alarm_mm_q <= 6'd0;
      tick_q     <= 1'b0;
      day_wrap_q <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      alarm_hh_q <= alarm_hh_d;
      alarm_mm_q <= alarm_mm_d;
      tick_q     <= tick_d;
      day_wrap_q <= day_wrap_d;
      alarm_q    <= alarm_d;
      load_err_q <= load_err_d;
    end
  end

  // Display: combinational from the stored 24-hour value.
  always_comb begin
    disp_hour = hour_q;
    pm        = 1'b0;
    if (mode_12h) begin
      pm = (hour_q >= 5'd12);
      if (hour_q == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour_q > 5'd12) begin
        disp_hour = hour_q - 5'd12;
      end
    end
  end

  assign sec      = sec_q;
  assign min      = min_q;
  assign hour     = hour_q;
  assign tick     = tick_q;
  assign day_wrap = day_wrap_q;
  assign alarm    = alarm_q;
  assign load_err = load_err_q;

endmodule

// File: doc/hms_clock.md
# hms_clock

Parametrised time-of-day counter: hours, minutes, seconds, with a built-in prescaler, run/pause, synchronous time load, 12/24-hour display and an HH:MM alarm. It takes the system clock, derives a one-second tick from `TICK_DIV` clock cycles, and feeds display and alarm logic in the timekeeping subsystem. It extends the plain second/minute counter with hours, prescaling, loading and alarm behaviour.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per second; legal range is ≥1. The prescaler width is `$clog2(TICK_DIV)`, minimum 1 bit.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low. All state is cleared while low.
- `en`  in  1  run enable; 0 freezes the prescaler and the time.
- `load`  in  1  one-cycle request to load the time from the three inputs below.
- `load_hh`  in  5  hour to load, 0–23.
- `load_mm`  in  6  minute to load, 0–59.
- `load_ss`  in  6  second to load, 0–59.
- `alarm_set`  in  1  captures `alarm_hh` and `alarm_mm` into the alarm registers.
- `alarm_hh`  in  5  alarm hour, 0–23.
- `alarm_mm`  in  6  alarm minute, 0–59.
- `alarm_en`  in  1  alarm enable level.
- `alarm_clr`  in  1  clears a latched alarm.
- `mode_12h`  in  1  display mode: 1 = 12-hour, 0 = 24-hour.
- `sec`  out  6  seconds, 0–59.
- `min`  out  6  minutes, 0–59.
- `hour`  out  5  hours, 0–23, always 24-hour.
- `disp_hour`  out  5  hour in the selected display format.
- `pm`  out  1  PM indicator; valid only in 12-hour mode.
- `tick`  out  1  one-cycle pulse marking each second advance.
- `day_wrap`  out  1  one-cycle pulse on 23:59:59 → 00:00:00.
- `alarm`  out  1  latched alarm flag.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- **Reset values.** `sec`, `min`, `hour`, prescaler, alarm registers (00:00), `tick`, `day_wrap`, `alarm` and `load_err` all reset to 0. Therefore `disp_hour` = 0 in 24-hour mode or 12 in 12-hour mode, and `pm` = 0.
- **Prescaler.**
  - When `en`=1, it counts 0 … `TICK_DIV`-1, then wraps to 0.
  - The edge at which it holds `TICK_DIV`-1 with `en`=1 is an "advance edge".
  - When `en`=0, it holds its value.
  - With `TICK_DIV`=1, every enabled cycle is an advance edge.
- **Advance edge.**
  - `sec`+1, wrapping at 59 → 0.
  - On the `sec` wrap, `min`+1, wrapping at 59 → 0.
  - On the `min` wrap, `hour`+1, wrapping at 23 → 0.
  - All fields update on the same edge.
- **Load.**
  - Priority: load > advance. When `load`=1, no advance occurs that cycle.
  - Valid values (hh≤23, mm≤59, ss≤59): the time takes the load values, the prescaler clears to 0, and `tick`/`day_wrap` stay low.
  - Invalid values: time and prescaler are unchanged, and `load_err` pulses for 1 cycle.
  - Load acts regardless of `en`.
- **Alarm registers.**
  - `alarm_set`=1 captures `alarm_hh`/`alarm_mm` when both are in range.
  - Out-of-range values are ignored; `load_err` is not asserted for them.
- **Alarm fire.** The alarm fires on an advance edge whose resulting time equals alarm_hh:alarm_mm:00 while `alarm_en`=1. `alarm` is then set.
- **Alarm hold and clear.**
  - `alarm` holds until `alarm_clr`=1, or `alarm_en`=0, at a clock edge.
  - If a fire and `alarm_clr` occur on the same edge, the fire wins and `alarm` = 1.
  - A load onto the alarm time never fires the alarm.
- **Display** (combinational from `hour` and `mode_12h`).
  - 24-hour mode: `disp_hour` = `hour`, `pm` = 0.
  - 12-hour mode:
    - `hour`=0 → `disp_hour` = 12.
    - `hour` 1–12 → `disp_hour` = `hour`.
    - `hour` 13–23 → `disp_hour` = `hour`-12.
    - `pm` = (`hour` ≥ 12).

## Timing
- **Advance-edge outputs.** `tick`, `day_wrap`, `alarm` and the new time are all registered. They become visible together in the cycle after the advance edge.
- **Pulse width.** `tick` and `day_wrap` are high for exactly 1 cycle. They are never asserted on a load cycle.
- **Second spacing.** While `en`=1 continuously, consecutive `tick` pulses are exactly `TICK_DIV` cycles apart. After a valid load, the first `tick` comes `TICK_DIV` enabled cycles later.
- **Pause.** Deasserting `en` for N cycles delays the next `tick` by exactly N cycles, because the prescaler phase is preserved.
- **Load response.** `load_err` appears 1 cycle after the `load` edge. Loaded values are visible 1 cycle after the `load` edge.
- **Display latency.** `disp_hour` and `pm` have zero latency from `hour` and `mode_12h`.
- **Reset mid-operation.** Asserting `rst_n`=0 clears all state immediately, with no clock required. Counting restarts from 00:00:00 with prescaler 0 after release.

## Test plan
- **Reset and count.** `TICK_DIV`=4, `en`=1, release reset → `tick` every 4 cycles; `sec` goes 1, 2, 3 …; after 240 cycles, `min`=1 and `sec`=0.
- **Rollover.** Load 23:59:58, `en`=1 → 23:59:59 after 4 cycles, then 00:00:00 with `day_wrap`=1 and `tick`=1 for 1 cycle.
- **Load priority and invalid load.**
  - `load`=1 on an advance edge with 10:20:30 → time = 10:20:30, no `tick`.
  - Load 24:00:00 → time unchanged, `load_err` pulses for 1 cycle.
- **Alarm.**
  - Alarm set to 07:30, `alarm_en`=1, load 07:29:59 → `alarm`=1 at 07:30:00 and stays high.
  - `alarm_clr` on the fire edge → `alarm` = 1.
  - A later `alarm_clr` → `alarm` = 0.
  - Loading 07:30:00 directly → no alarm.
- **12-hour display.** `mode_12h`=1 with `hour` = 0, 12, 13, 23 → (`disp_hour`, `pm`) = (12,0), (12,1), (1,1), (11,1).
- **Pause and async reset.**
  - `en`=0 for 7 cycles mid-second → next `tick` delayed by exactly 7 cycles.
  - `rst_n`=0 between clock edges → all outputs 0 immediately.
